change_payout_ctrl: RTL and testbench
=====================================

// Module: change_payout_ctrl
// PURPOSE
// - Actuator side of the vend/change interface: consumes the registered dispense/change outputs of the coin FSM.
// - Drives the product motor and a single 5rs coin hopper, and confirms each action from its drop sensor.
// - Handles sensor timeouts with hopper retries; reports busy, done and a sticky fault to the front panel.
// PARAMETERS
// - PULSE_CYCLES    4     eject solenoid pulse width, cycles (>=1)
// - TIMEOUT_CYCLES  1000  max cycles to wait for a sensor event per attempt (>=PULSE_CYCLES+4)
// - MAX_RETRY       2     extra eject attempts per coin before fault (0..3)
// - CNT_W           16    timer width; must hold TIMEOUT_CYCLES
// PORTS
// - clk            in   1  clock
// - reset          in   1  reset, synchronous, active-high
// - dispense       in   1  vend request, level from coin FSM
// - change         in   2  refund request: 00 none, 01 5rs, 10 10rs, 11 reserved
// - product_sense  in   1  async product-drop sensor, active-high
// - coin_sense     in   1  async coin-exit sensor, active-high
// - motor_on       out  1  product motor drive
// - eject          out  1  hopper solenoid pulse (one 5rs coin per pulse)
// - busy           out  1  high in every state except IDLE
// - done           out  1  one-cycle pulse, request fully serviced
// - fault          out  1  sticky fault, cleared only by reset
// - fault_code     out  2  00 none, 01 vend timeout, 10 hopper empty, 11 bad request
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, synchronizers cleared. Reset mid-operation aborts immediately; motor/eject drop the next edge.
// - Sensors: 2-FF synchronizer, then rising-edge detect. An event is seen 3 cycles after the sensor rises. Only edges count; a held-high level counts once.
// - Request accept, IDLE only: when dispense=1 or change!=00, at edge N latch dispense and coin count.
//   - Coin count: 01->1, 10->2. Inputs are ignored while busy.
// - change=11 in IDLE -> FAULT, code 11, no actuation.
// - States:
//   - IDLE: if vend latched -> VEND, else if coins>0 -> EJECT.
//   - VEND: motor_on=1 from N+1. On product event -> motor off; go EJECT if coins>0, else DONE.
//     - Timer reaches TIMEOUT_CYCLES -> FAULT, code 01.
//   - EJECT: eject=1 for exactly PULSE_CYCLES cycles, then WAIT_COIN. A coin event during EJECT counts.
//   - WAIT_COIN: on coin event, coins-=1 and retry=0; go EJECT if coins>0, else DONE.
//     - Timer (started at EJECT entry) reaches TIMEOUT_CYCLES: if retry<MAX_RETRY, retry+=1 and go EJECT; else FAULT, code 10.
//   - DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE.
//   - FAULT: fault=1, outputs off, no exit except reset.
// - Counter limits: timer saturates and restarts on every state entry. Spurious sensor events in IDLE/DONE/FAULT are ignored.
// - A coin event in the same cycle as the timeout takes priority: the coin counts.
// - Coins never exceed 2; an extra coin event after coins reach 0 is ignored.
// - dispense=1 with change!=00: vend first, then coins, then a single done.
// STRUCTURE
// - Package vend_pkg holds:
//   - change codes CHG_NONE/CHG_5/CHG_10/CHG_RSVD
//   - fault codes FLT_NONE/FLT_VEND/FLT_HOPPER/FLT_BADREQ
//   - state encoding IDLE/VEND/EJECT/WAIT_COIN/DONE/FAULT
// - Sub-module sense_sync_edge (2-FF synchronizer + rise detect, synchronous reset), instantiated once per sensor.
// - Top holds the FSM, timer, retry counter and coin counter; all outputs are registered.
// TESTING (PULSE_CYCLES=4, TIMEOUT_CYCLES=20, MAX_RETRY=2)
// - dispense=1, change=00; product_sense rises 5 cycles later -> motor_on 1 from N+1 until the event; one done pulse; fault=0.
// - change=10; coin_sense pulses 2 cycles after each eject falls -> two 4-cycle eject pulses, done once, busy low after.
// - change=01, coin_sense never rises -> 3 eject pulses (1+2 retries), then fault=1, fault_code=10; stays until reset.
// - dispense=1, no product_sense -> motor_on drops after 20 cycles, fault_code=01; a later coin input is ignored.
// - change=11 in IDLE -> fault_code=11, no motor/eject; reset asserted during EJECT -> eject=0, busy=0 the next cycle.
// - change=10 toggling while busy, plus coin_sense held high for 10 cycles -> no re-accept; the held level counts as one coin.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared encodings for the vend/change actuator block.
package vend_pkg;

  // Refund request codes as presented by the coin FSM.
  typedef enum logic [1:0] {
    CHG_NONE = 2'b00,
    CHG_5    = 2'b01,
    CHG_10   = 2'b10,
    CHG_RSVD = 2'b11
  } change_e;

  // Sticky fault reasons reported to the front panel.
  typedef enum logic [1:0] {
    FLT_NONE   = 2'b00,
    FLT_VEND   = 2'b01,
    FLT_HOPPER = 2'b10,
    FLT_BADREQ = 2'b11
  } fault_e;

  // Actuator sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VEND      = 3'd1,
    EJECT     = 3'd2,
    WAIT_COIN = 3'd3,
    DONE      = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // Number of 5rs coins to pay out for a refund code.
  function automatic logic [1:0] coins_for(input logic [1:0] chg);
    logic [1:0] n;
    n = 2'd0;
    case (chg)
      CHG_5:   n = 2'd1;
      CHG_10:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/change_payout_ctrl_if.sv
// Request, sensor and actuator signals between the coin FSM side and the payout block.
interface change_payout_ctrl_if;
  import vend_pkg::*;

  logic       dispense;
  logic [1:0] change;
  logic       product_sense;
  logic       coin_sense;
  logic       motor_on;
  logic       eject;
  logic       busy;
  logic       done;
  logic       fault;
  fault_e     fault_code;

  // Requester / sensor side.
  modport master (
    output dispense, change, product_sense, coin_sense,
    input  motor_on, eject, busy, done, fault, fault_code
  );

  // Payout controller side.
  modport slave (
    input  dispense, change, product_sense, coin_sense,
    output motor_on, eject, busy, done, fault, fault_code
  );

endinterface

// File: rtl/sense_sync_edge.sv
// Two-flop synchronizer for an asynchronous drop sensor followed by a rising-edge detector.
// rise_o is high for one cycle, two edges after the sensor is first sampled high,
// so the consuming FSM acts on the third edge.
module sense_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sense_i,
  output logic rise_o
);

  // [0] first sync stage, [1] second sync stage, [2] previous synchronized level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw sensor through the synchronizer and history stage.
  always_comb begin
    sync_d = {sync_q[1:0], sense_i};
  end

  // Synchronizer and history register.
  // NOTE: non-blocking assignments here so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/change_payout_ctrl.sv
// Payout actuator sequencer: runs the product motor and the 5rs hopper, confirms each
// action from its drop sensor, retries the hopper on timeout and latches a sticky fault.
module change_payout_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned CNT_W          = 16
) (
  input logic                 clk,
  input logic                 reset,
  change_payout_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
  localparam logic [1:0]       MAX_R      = 2'(MAX_RETRY);

  logic product_evt;
  logic coin_evt;

  sense_sync_edge u_prod_sense (
    .clk    (clk),
    .reset  (reset),
    .sense_i(bus.product_sense),
    .rise_o (product_evt)
  );

  sense_sync_edge u_coin_sense (
    .clk    (clk),
    .reset  (reset),
    .sense_i(bus.coin_sense),
    .rise_o (coin_evt)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       coins_q, coins_d;
  logic             coin_pend_q, coin_pend_d;
  fault_e           code_q, code_d;

  logic   motor_on_q, motor_on_d;
  logic   eject_q, eject_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   fault_q, fault_d;
  fault_e fault_code_q, fault_code_d;

  // Next-state, counter updates and registered-output decode.
  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
    retry_d     = retry_q;
    coins_d     = coins_q;
    coin_pend_d = coin_pend_q;
    code_d      = code_q;

    case (state_q)
      IDLE: begin
        timer_d     = '0;
        retry_d     = '0;
        coin_pend_d = 1'b0;
        if (bus.change == CHG_RSVD) begin
          state_d = FAULT;
          code_d  = FLT_BADREQ;
        end else if (bus.dispense || bus.change != CHG_NONE) begin
          coins_d = coins_for(bus.change);
          state_d = bus.dispense ? VEND : EJECT;
        end
      end
      VEND: begin
        // A product drop on the timeout cycle still counts as a successful vend.
        if (product_evt)              state_d = (coins_q != 2'd0) ? EJECT : DONE;
        else if (timer_q == TMO_LAST) begin
          state_d = FAULT;
          code_d  = FLT_VEND;
        end
      end
      EJECT: begin
        // A fast coin can drop while the solenoid is still energised; remember it.
        if (coin_evt)                 coin_pend_d = 1'b1;
        if (timer_q == PULSE_LAST)    state_d = WAIT_COIN;
      end
      WAIT_COIN: begin
        // Coin confirmation wins over a simultaneous timeout.
        if (coin_evt || coin_pend_q) begin
          coins_d     = coins_q - 2'd1;
          retry_d     = '0;
          coin_pend_d = 1'b0;
          state_d     = (coins_q > 2'd1) ? EJECT : DONE;
        end else if (timer_q == TMO_LAST) begin
          coin_pend_d = 1'b0;
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            state_d = EJECT;
          end else begin
            state_d = FAULT;
            code_d  = FLT_HOPPER;
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // The timer restarts on every state entry except EJECT->WAIT_COIN, where one
    // timeout window covers the whole eject attempt.
    if (state_d != state_q && !(state_q == EJECT && state_d == WAIT_COIN)) timer_d = '0;

    motor_on_d   = (state_q == VEND);
    eject_d      = (state_q == EJECT);
    busy_d       = (state_q != IDLE);
    done_d       = (state_q == DONE);
    fault_d      = (state_q == FAULT);
    fault_code_d = (state_q == FAULT) ? code_q : FLT_NONE;
  end

  // State, counters and output registers; reset aborts any operation at the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      coins_q      <= '0;
      coin_pend_q  <= 1'b0;
      code_q       <= FLT_NONE;
      motor_on_q   <= 1'b0;
      eject_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      coins_q      <= coins_d;
      coin_pend_q  <= coin_pend_d;
      code_q       <= code_d;
      motor_on_q   <= motor_on_d;
      eject_q      <= eject_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.motor_on   = motor_on_q;
  assign bus.eject      = eject_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Self-checking bench for change_payout_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_change_payout_ctrl;
  import vend_pkg::*;

  localparam int PULSE = 4;
  localparam int TMO   = 20;
  localparam int MAXR  = 2;

  logic clk = 1'b0;
  logic reset;

  change_payout_ctrl_if bus ();

  change_payout_ctrl #(
    .PULSE_CYCLES  (PULSE),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       disp;
    logic [1:0] chg;
    int         pdelay;   // cycles after motor rises before product drops; -1 = never
    logic [7:0] plan;     // bit k: coin drops after eject attempt k
    int         dly;      // cycles after eject falls before coin drops
    int         exp_m;    // motor_on high cycles
    int         exp_p;    // eject pulses
    int         exp_d;    // done pulses
    int         exp_code; // final fault code
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation from the request and the sensor scenario.
  function automatic void model(input logic disp, input logic [1:0] chg, input int pd,
                                input logic [7:0] plan, output int em, output int ep,
                                output int ed, output int ecode);
    int   coins;
    int   att;
    logic got;
    em = 0; ep = 0; ed = 0; ecode = 0;
    if (chg == 2'b11) begin ecode = 3; return; end
    coins = (chg == 2'b01) ? 1 : (chg == 2'b10) ? 2 : 0;
    if (disp) begin
      if (pd < 0) begin em = TMO; ecode = 1; return; end
      // 3-cycle sensor latency plus one cycle for the registered motor output
      em = pd + 4;
    end
    att = 0;
    for (int c = 0; c < coins; c++) begin
      got = 1'b0;
      for (int t = 0; t <= MAXR && !got; t++) begin
        ep++;
        got = plan[att];
        att++;
      end
      if (!got) begin ecode = 2; return; end
    end
    ed = 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.dispense = 1'b0;
    bus.change = 2'b00;
    bus.product_sense = 1'b0;
    bus.coin_sense = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request and play the sensor scenario, measuring the actuator activity.
  task automatic run_txn(input logic disp, input logic [1:0] chg, input int pdelay,
                         input logic [7:0] plan, input int dly, output int mc,
                         output int pc, output int ec, output int dc, output int code);
    logic prev_m, prev_e, finished;
    int   p_cd, c_cd, p_hold, c_hold, att;
    mc = 0; pc = 0; ec = 0; dc = 0; code = 0;
    prev_m = 1'b0; prev_e = 1'b0; finished = 1'b0;
    p_cd = -1; c_cd = -1; p_hold = 0; c_hold = 0; att = 0;
    @(negedge clk);
    bus.dispense = disp;
    bus.change   = chg;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      bus.dispense = 1'b0;
      bus.change   = 2'b00;
      mc += int'(bus.motor_on);
      ec += int'(bus.eject);
      dc += int'(bus.done);
      if (bus.eject && !prev_e) pc++;
      if (bus.done) check("done_with_busy", int'(bus.busy), 1);
      if (p_hold > 0) begin p_hold--; if (p_hold == 0) bus.product_sense = 1'b0; end
      if (c_hold > 0) begin c_hold--; if (c_hold == 0) bus.coin_sense = 1'b0; end
      if (bus.motor_on && !prev_m && pdelay >= 0) p_cd = pdelay;
      if (!bus.eject && prev_e) begin
        if (att < 8 && plan[att]) c_cd = dly;
        att++;
      end
      if (p_cd == 0) begin bus.product_sense = 1'b1; p_hold = 3; end
      if (p_cd >= 0) p_cd--;
      if (c_cd == 0) begin bus.coin_sense = 1'b1; c_hold = 2; end
      if (c_cd >= 0) c_cd--;
      prev_m = bus.motor_on;
      prev_e = bus.eject;
      if (bus.fault) begin
        code = int'(bus.fault_code);
        finished = 1'b1;
      end else if (dc > 0 && !bus.busy) begin
        finished = 1'b1;
      end
    end
    check("txn_completes", int'(finished), 1);
  endtask

  // After a fault, a new request must not actuate anything and the fault must hold.
  task automatic sticky_after(input logic disp, input logic [1:0] chg, input int exp_code,
                              input string tag);
    int mc, pc, ec, dc, code, ej, mo;
    do_reset();
    run_txn(disp, chg, -1, 8'h00, 0, mc, pc, ec, dc, code);
    check({tag, "_code"}, code, exp_code);
    @(negedge clk);
    bus.change = 2'b01;
    bus.dispense = 1'b1;
    ej = 0; mo = 0;
    repeat (30) begin
      @(negedge clk);
      bus.change = 2'b00;
      bus.dispense = 1'b0;
      ej += int'(bus.eject);
      mo += int'(bus.motor_on);
    end
    check({tag, "_no_eject"}, ej, 0);
    check({tag, "_no_motor"}, mo, 0);
    check({tag, "_fault_held"}, int'(bus.fault), 1);
    check({tag, "_code_held"}, int'(bus.fault_code), exp_code);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int mc, pc, ec, dc, code;
    int em, ep, ed, ecode;
    int seen, falls, c_hold, c_cd, idle_busy;
    logic prev_e, finished, disp;
    logic [1:0] chg;
    logic [7:0] plan;
    int pd, dly;

    //            disp  chg    pd  plan          dly  m   p  d  code
    vecs[0] = '{1'b1, 2'b00,  5, 8'b0000_0000, 0,   9, 0, 1, 0};
    vecs[1] = '{1'b0, 2'b10, -1, 8'b0000_0011, 2,   0, 2, 1, 0};
    vecs[2] = '{1'b0, 2'b01, -1, 8'b0000_0000, 0,   0, 3, 0, 2};
    vecs[3] = '{1'b1, 2'b00, -1, 8'b0000_0000, 0,  20, 0, 0, 1};
    vecs[4] = '{1'b0, 2'b11, -1, 8'b0000_0000, 0,   0, 0, 0, 3};
    vecs[5] = '{1'b1, 2'b10,  3, 8'b0000_0101, 1,   7, 3, 1, 0};
    vecs[6] = '{1'b0, 2'b10, -1, 8'b0000_0100, 3,   0, 6, 0, 2};
    vecs[7] = '{1'b1, 2'b01, -1, 8'b0000_0001, 0,  20, 0, 0, 1};
    vecs[8] = '{1'b1, 2'b11,  2, 8'b0000_0001, 0,   0, 0, 0, 3};

    reset = 1'b1;
    bus.dispense = 1'b0;
    bus.change = 2'b00;
    bus.product_sense = 1'b0;
    bus.coin_sense = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_motor_on", int'(bus.motor_on), 0);
    check("rst_eject", int'(bus.eject), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_fault_code", int'(bus.fault_code), 0);

    // Directed vector table
    foreach (vecs[i]) begin
      do_reset();
      run_txn(vecs[i].disp, vecs[i].chg, vecs[i].pdelay, vecs[i].plan, vecs[i].dly,
              mc, pc, ec, dc, code);
      check($sformatf("vec%0d_motor_cycles", i), mc, vecs[i].exp_m);
      check($sformatf("vec%0d_eject_pulses", i), pc, vecs[i].exp_p);
      check($sformatf("vec%0d_eject_cycles", i), ec, PULSE * vecs[i].exp_p);
      check($sformatf("vec%0d_done", i), dc, vecs[i].exp_d);
      check($sformatf("vec%0d_fault_code", i), code, vecs[i].exp_code);
    end

    // Motor on from the cycle after the accepting edge
    do_reset();
    @(negedge clk);
    bus.dispense = 1'b1;
    @(negedge clk);
    bus.dispense = 1'b0;
    @(negedge clk);
    check("motor_on_n1", int'(bus.motor_on), 1);
    check("busy_n1", int'(bus.busy), 1);

    // Sticky faults ignore later requests
    sticky_after(1'b1, 2'b00, 1, "vend_tmo");
    sticky_after(1'b0, 2'b01, 2, "hopper");

    // Reset asserted while ejecting
    do_reset();
    @(negedge clk);
    bus.change = 2'b01;
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      @(negedge clk);
      bus.change = 2'b00;
      if (bus.eject) seen = 1;
    end
    check("eject_seen_before_reset", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_eject_eject", int'(bus.eject), 0);
    check("reset_mid_eject_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Change toggling while busy; coin sensor held high counts once
    do_reset();
    @(negedge clk);
    bus.change = 2'b10;
    pc = 0; dc = 0; falls = 0; c_hold = 0; c_cd = -1; prev_e = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (falls < 2) bus.change = 2'($urandom_range(0, 3));
      else           bus.change = 2'b00;
      if (bus.eject && !prev_e) pc++;
      dc += int'(bus.done);
      if (c_hold > 0) begin c_hold--; if (c_hold == 0) bus.coin_sense = 1'b0; end
      if (!bus.eject && prev_e) begin
        falls++;
        if (falls == 1) begin bus.coin_sense = 1'b1; c_hold = 10; end
        else            c_cd = 4;
      end
      if (c_cd == 0) begin bus.coin_sense = 1'b1; c_hold = 2; end
      if (c_cd >= 0) c_cd--;
      prev_e = bus.eject;
      if (dc > 0 && !bus.busy) finished = 1'b1;
    end
    check("held_coin_completes", int'(finished), 1);
    idle_busy = 0;
    repeat (10) begin
      @(negedge clk);
      idle_busy += int'(bus.busy);
      if (bus.eject && !prev_e) pc++;
      prev_e = bus.eject;
    end
    check("held_coin_pulses", pc, 2);
    check("held_coin_done", dc, 1);
    check("held_coin_fault", int'(bus.fault), 0);
    check("no_reaccept_busy", idle_busy, 0);

    // Randomized transactions against the model
    for (int r = 0; r < 30; r++) begin
      disp = 1'($urandom_range(0, 1));
      chg  = 2'($urandom_range(0, 2));
      if (!disp && chg == 2'b00) chg = 2'($urandom_range(1, 2));
      pd   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 12));
      for (int b = 0; b < 8; b++) plan[b] = ($urandom_range(0, 3) != 0);
      dly  = int'($urandom_range(0, 6));
      model(disp, chg, pd, plan, em, ep, ed, ecode);
      do_reset();
      run_txn(disp, chg, pd, plan, dly, mc, pc, ec, dc, code);
      check($sformatf("rnd%0d_motor_cycles", r), mc, em);
      check($sformatf("rnd%0d_eject_pulses", r), pc, ep);
      check($sformatf("rnd%0d_eject_cycles", r), ec, PULSE * ep);
      check($sformatf("rnd%0d_done", r), dc, ed);
      check($sformatf("rnd%0d_fault_code", r), code, ecode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
